// File: rtl/aes_key_expander_pkg.sv
// Shared AES types, key-size helpers and GF(2^8) arithmetic used by the key
// expander and, later, the cipher datapath.
package aes_key_expander_pkg;

  typedef logic         ulogic1;
  typedef logic [3:0]   ulogic4;
  typedef logic [7:0]   ulogic8;
  typedef logic [31:0]  ulogic32;
  typedef logic [127:0] ulogic128;

  typedef ulogic32 aes_word_t;

  localparam int AES_BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    DRAIN
  } kx_state_t;

  function automatic int aes_nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int aes_nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  // Multiply by x in GF(2^8), reducing with the AES polynomial 0x11B.
  function automatic ulogic8 xtime(input ulogic8 b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_key_expander_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox
  import aes_key_expander_pkg::*;
(
  input  ulogic8 plain,
  output ulogic8 subst
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign subst = SBOX[plain];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key expansion: one 32-bit word per clock, emitted as 128-bit
// round keys over a valid/ready port that stalls word generation when full.
module aes_key_expander
  import aes_key_expander_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  ulogic1              clk,
  input  ulogic1              reset,
  input  logic [KEY_BITS-1:0] key_in,
  input  ulogic1              key_valid,
  output ulogic1              key_ready,
  output ulogic128            rk_data,
  output ulogic4              rk_round,
  output ulogic1              rk_last,
  output ulogic1              rk_valid,
  input  ulogic1              rk_ready,
  output ulogic1              busy
);

  localparam int NK     = aes_nk(KEY_BITS);
  localparam int NR     = aes_nr(KEY_BITS);
  localparam int NWORDS = 4 * (NR + 1);
  localparam logic [5:0] LAST_I = 6'(NWORDS - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  kx_state_t  state, state_nxt;
  logic [5:0] i;
  logic [2:0] widx;
  ulogic8     rcon;
  aes_word_t  win [8];
  aes_word_t  asm_q [3];
  aes_word_t  sub_in, sub_out, new_word;
  logic [255:0] key_ext;
  logic accept, advance, load, xfer, word4;

  assign key_ext = 256'(key_in);

  always_comb begin
    state_nxt = state;
    key_ready = (state == IDLE);
    busy      = (state != IDLE);
    accept    = key_valid && (state == IDLE);
    xfer      = rk_valid && rk_ready;
    word4     = (i[1:0] == 2'd3);
    // A word that would complete a round waits until the output slot frees up.
    advance   = (state == GEN) && !(word4 && rk_valid && !rk_ready);
    load      = advance && word4;
    unique case (state)
      IDLE:    if (key_valid) state_nxt = GEN;
      GEN:     if (advance && i == LAST_I) state_nxt = DRAIN;
      DRAIN:   if (xfer && rk_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sub_in   = (widx == 3'd0) ? {win[0][23:0], win[0][31:24]} : win[0];
    new_word = win[NK-1] ^ win[0];
    if (i < 6'(NK)) begin
      new_word = win[NK-1];
    end else if (widx == 3'd0) begin
      new_word = win[NK-1] ^ sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && widx == 3'd4) begin
      new_word = win[NK-1] ^ sub_out;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .plain (sub_in[8*b +: 8]),
      .subst (sub_out[8*b +: 8])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // win[0] is w[i-1] and win[NK-1] is w[i-NK]; the key is loaded reversed so
  // the first NK advances simply rotate the key words out in order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i        <= '0;
      widx     <= '0;
      rcon     <= 8'h01;
      rk_data  <= '0;
      rk_round <= '0;
      rk_last  <= 1'b0;
      rk_valid <= 1'b0;
      for (int j = 0; j < 8; j++) win[j] <= '0;
      for (int j = 0; j < 3; j++) asm_q[j] <= '0;
    end else begin
      if (accept) begin
        i    <= '0;
        widx <= '0;
        rcon <= 8'h01;
        for (int j = 0; j < 8; j++) win[j] <= (j < NK) ? key_ext[32*j +: 32] : '0;
      end else if (advance) begin
        win[0] <= new_word;
        for (int j = 1; j < 8; j++) win[j] <= win[j-1];
        i    <= i + 6'd1;
        widx <= (widx == 3'(NK - 1)) ? 3'd0 : widx + 3'd1;
        if (i >= 6'(NK) && widx == 3'd0) rcon <= xtime(rcon);
        case (i[1:0])
          2'd0:    asm_q[0] <= new_word;
          2'd1:    asm_q[1] <= new_word;
          2'd2:    asm_q[2] <= new_word;
          default: ;
        endcase
      end

      if (load) begin
        rk_data  <= {asm_q[0], asm_q[1], asm_q[2], new_word};
        rk_round <= i[5:2];
        rk_last  <= (i[5:2] == 4'(NR));
        rk_valid <= 1'b1;
      end else if (xfer) begin
        rk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: 128/192/256-bit instances checked against a
// FIPS-197 reference model through an in-order round-key scoreboard.
module tb_aes_key_expander;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  logic         kv [3];
  logic         rr [3];
  logic         kr [3];
  logic         rv [3];
  logic         rl [3];
  logic         bz [3];
  logic [127:0] rd [3];
  logic [3:0]   rn [3];

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } exp_t;
  exp_t sb_q[$];
  logic [7:0] sb [256];

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

  aes_key_expander #(.KEY_BITS(128)) u128 (
    .clk(clk), .reset(rst), .key_in(k128), .key_valid(kv[0]), .key_ready(kr[0]),
    .rk_data(rd[0]), .rk_round(rn[0]), .rk_last(rl[0]), .rk_valid(rv[0]),
    .rk_ready(rr[0]), .busy(bz[0]));

  aes_key_expander #(.KEY_BITS(192)) u192 (
    .clk(clk), .reset(rst), .key_in(k192), .key_valid(kv[1]), .key_ready(kr[1]),
    .rk_data(rd[1]), .rk_round(rn[1]), .rk_last(rl[1]), .rk_valid(rv[1]),
    .rk_ready(rr[1]), .busy(bz[1]));

  aes_key_expander #(.KEY_BITS(256)) u256 (
    .clk(clk), .reset(rst), .key_in(k256), .key_valid(kv[2]), .key_ready(kr[2]),
    .rk_data(rd[2]), .rk_round(rn[2]), .rk_last(rl[2]), .rk_valid(rv[2]),
    .rk_ready(rr[2]), .busy(bz[2]));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    exp_t        e;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int k = 0; k < nk; k++) w[k] = key[32*(nk-1-k) +: 32];
    for (int k = nk; k < 4*(nr+1); k++) begin
      t = w[k-1];
      if (k % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && k % nk == 4) begin
        t = sub_word(t);
      end
      w[k] = w[k-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) begin
      e.data  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      e.round = 4'(r);
      e.last  = (r == nr);
      sb_q.push_back(e);
    end
  endtask

  task automatic start_key(input int d, input logic [255:0] key);
    @(posedge clk); #1;
    k128 = key[127:0]; k192 = key[191:0]; k256 = key; kv[d] = 1'b1;
    @(posedge clk); #1 kv[d] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin kv[d] = 1'b0; rr[d] = 1'b0; end
    k128 = '0; k192 = '0; k256 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      vectors++;
      if (rv[d] !== 1'b0 || rd[d] !== 128'h0 || rn[d] !== 4'h0 || rl[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_outputs dut%0d got valid=%b data=%h round=%0d last=%b want 0/0/0/0",
                 d, rv[d], rd[d], rn[d], rl[d]);
      end
      vectors++;
      if (kr[d] !== 1'b1 || bz[d] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_status dut%0d got key_ready=%b busy=%b want 1/0", d, kr[d], bz[d]);
      end
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_aes128();
    exp_t e;
    int   got;
    sb_q.delete();
    model_expand(256'(KEY_A), 4);
    rr[0] = 1'b1;
    start_key(0, 256'(KEY_A));
    got = 0;
    for (int n = 1; n <= 60 && got < 11; n++) begin
      @(posedge clk); @(negedge clk);
      if (rv[0] === 1'b1) begin
        if (sb_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL aes128_extra round=%0d data=%h want none", rn[0], rd[0]);
        end else begin
          e = sb_q.pop_front();
          vectors++;
          if (rd[0] !== e.data || rn[0] !== e.round || rl[0] !== e.last) begin
            miscompares++;
            $display("FAIL aes128_round got r%0d %h last=%b want r%0d %h last=%b",
                     rn[0], rd[0], rl[0], e.round, e.data, e.last);
          end
          vectors++;
          if (n != 4 * (int'(e.round) + 1)) begin
            miscompares++;
            $display("FAIL aes128_latency round %0d at edge %0d want %0d", e.round, n, 4*(e.round+1));
          end
          if (e.round == 4'd1) begin
            vectors++;
            if (rd[0] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
              miscompares++;
              $display("FAIL aes128_round1 got %h want a0fafe1788542cb123a339392a6c7605", rd[0]);
            end
          end
          if (e.round == 4'd10) begin
            vectors++;
            if (rd[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || rl[0] !== 1'b1 || n != 44) begin
              miscompares++;
              $display("FAIL aes128_round10 got %h last=%b edge %0d want d014f9a8c9ee2589e13f0cc8b6630ca6 1 44",
                       rd[0], rl[0], n);
            end
            vectors++;
            if (kr[0] !== 1'b0 || bz[0] !== 1'b1) begin
              miscompares++;
              $display("FAIL aes128_busy_drain got key_ready=%b busy=%b want 0/1", kr[0], bz[0]);
            end
          end
          got++;
        end
      end
    end
    vectors++;
    if (got != 11) begin
      miscompares++;
      $display("FAIL aes128_count got %0d rounds want 11", got);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if (kr[0] !== 1'b1 || bz[0] !== 1'b0 || rv[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL aes128_idle_after got key_ready=%b busy=%b valid=%b want 1/0/0", kr[0], bz[0], rv[0]);
    end
  endtask

  task automatic test_long_keys();
    exp_t         e;
    int           got, nk;
    logic [255:0] key;
    logic [127:0] lit;
    for (int d = 1; d < 3; d++) begin
      nk  = (d == 1) ? 6 : 8;
      key = (d == 1) ? 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b
                     : 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
      lit = (d == 1) ? 128'he98ba06f448c773c8ecc720401002202
                     : 128'hfe4890d1e6188d0b046df344706c631e;
      sb_q.delete();
      model_expand(key, nk);
      rr[d] = 1'b1;
      start_key(d, key);
      got = 0;
      for (int n = 1; n <= 80 && got < nk + 7; n++) begin
        @(posedge clk); @(negedge clk);
        if (rv[d] === 1'b1 && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          vectors++;
          if (rd[d] !== e.data || rn[d] !== e.round || rl[d] !== e.last) begin
            miscompares++;
            $display("FAIL key%0d_round got r%0d %h last=%b want r%0d %h last=%b",
                     nk*32, rn[d], rd[d], rl[d], e.round, e.data, e.last);
          end
          if (int'(e.round) == nk + 6) begin
            vectors++;
            if (rd[d] !== lit || int'(rn[d]) != nk + 6) begin
              miscompares++;
              $display("FAIL key%0d_final got r%0d %h want r%0d %h", nk*32, rn[d], rd[d], nk+6, lit);
            end
          end
          got++;
        end
      end
      vectors++;
      if (got != nk + 7) begin
        miscompares++;
        $display("FAIL key%0d_count got %0d rounds want %0d", nk*32, got, nk+7);
      end
      @(posedge clk); @(negedge clk);
      vectors++;
      if (kr[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL key%0d_idle_after got key_ready=%b want 1", nk*32, kr[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t         e;
    int           got;
    logic         held, pl;
    logic [127:0] pd;
    logic [3:0]   pn;
    sb_q.delete();
    model_expand(256'(KEY_A), 4);
    rr[0] = 1'b0;
    start_key(0, 256'(KEY_A));
    got = 0; held = 1'b0; pd = '0; pn = '0; pl = 1'b0;
    for (int n = 0; n < 1500 && got < 11; n++) begin
      @(posedge clk); #1 rr[0] = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      if (held) begin
        vectors++;
        if (rv[0] !== 1'b1 || rd[0] !== pd || rn[0] !== pn || rl[0] !== pl) begin
          miscompares++;
          $display("FAIL stall_stable got v=%b r%0d %h want v=1 r%0d %h", rv[0], rn[0], rd[0], pn, pd);
        end
      end
      if (rv[0] === 1'b1 && rr[0] === 1'b1) begin
        held = 1'b0;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          vectors++;
          if (rd[0] !== e.data || rn[0] !== e.round || rl[0] !== e.last) begin
            miscompares++;
            $display("FAIL bp_round got r%0d %h want r%0d %h", rn[0], rd[0], e.round, e.data);
          end
          got++;
        end
      end else begin
        held = (rv[0] === 1'b1);
        pd = rd[0]; pn = rn[0]; pl = rl[0];
      end
    end
    vectors++;
    if (got != 11) begin
      miscompares++;
      $display("FAIL bp_count got %0d rounds want 11", got);
    end
    rr[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   first;
    logic found;
    sb_q.delete();
    rr[0] = 1'b1;
    start_key(0, 256'(KEY_A));
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(posedge clk); @(negedge clk);
      if (rv[0] === 1'b1 && rn[0] === 4'd5) found = 1'b1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL midreset_reach got no round 5 want round 5 within 60 edges");
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (rv[0] !== 1'b0 || rd[0] !== 128'h0 || rn[0] !== 4'h0 || rl[0] !== 1'b0 ||
        bz[0] !== 1'b0 || kr[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_outputs got v=%b d=%h r=%0d l=%b busy=%b kr=%b want 0/0/0/0/0/1",
               rv[0], rd[0], rn[0], rl[0], bz[0], kr[0]);
    end
    @(posedge clk); @(negedge clk); #2 rst = 1'b0;
    model_expand(256'(KEY_B), 4);
    start_key(0, 256'(KEY_B));
    first = 0;
    for (int n = 1; n <= 8 && first == 0; n++) begin
      @(posedge clk); @(negedge clk);
      if (rv[0] === 1'b1) first = n;
    end
    e = sb_q.pop_front();
    vectors++;
    if (first != 4 || rd[0] !== e.data || rd[0] !== KEY_B || rn[0] !== 4'd0) begin
      miscompares++;
      $display("FAIL midreset_round0 got edge %0d r%0d %h want edge 4 r0 %h", first, rn[0], rd[0], KEY_B);
    end
    for (int n = 0; n < 60 && kr[0] !== 1'b1; n++) begin
      @(posedge clk); @(negedge clk);
    end
    vectors++;
    if (kr[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_drain got key_ready=%b want 1", kr[0]);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   got, first;
    sb_q.delete();
    model_expand(256'(KEY_A), 4);
    rr[0] = 1'b1;
    @(posedge clk); #1 k128 = KEY_A; kv[0] = 1'b1;
    @(posedge clk); #1 k128 = KEY_B;
    got = 0;
    for (int n = 1; n <= 60 && got < 11; n++) begin
      @(posedge clk); @(negedge clk);
      vectors++;
      if (kr[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_key_ready_busy edge %0d got %b want 0", n, kr[0]);
      end
      if (rv[0] === 1'b1 && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        vectors++;
        if (rd[0] !== e.data || rn[0] !== e.round || rl[0] !== e.last) begin
          miscompares++;
          $display("FAIL b2b_roundA got r%0d %h want r%0d %h", rn[0], rd[0], e.round, e.data);
        end
        got++;
      end
    end
    vectors++;
    if (got != 11) begin
      miscompares++;
      $display("FAIL b2b_countA got %0d rounds want 11", got);
    end
    model_expand(256'(KEY_B), 4);
    @(posedge clk); @(negedge clk);
    vectors++;
    if (kr[0] !== 1'b1 || bz[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle_gap got key_ready=%b busy=%b want 1/0", kr[0], bz[0]);
    end
    @(posedge clk); #1 kv[0] = 1'b0;
    @(negedge clk);
    vectors++;
    if (bz[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_accept got busy=%b want 1", bz[0]);
    end
    got = 0; first = 0;
    for (int n = 1; n <= 60 && got < 11; n++) begin
      @(posedge clk); @(negedge clk);
      if (rv[0] === 1'b1 && sb_q.size() != 0) begin
        if (first == 0) first = n;
        e = sb_q.pop_front();
        vectors++;
        if (rd[0] !== e.data || rn[0] !== e.round || rl[0] !== e.last) begin
          miscompares++;
          $display("FAIL b2b_roundB got r%0d %h want r%0d %h", rn[0], rd[0], e.round, e.data);
        end
        got++;
      end
    end
    vectors++;
    if (first != 4 || got != 11) begin
      miscompares++;
      $display("FAIL b2b_keyB got first edge %0d rounds %0d want 4 and 11", first, got);
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_aes128();
    test_long_keys();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
